// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead slice is
// resolved per stage, with a valid/ready handshake and a global stall enable.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / BLOCK;

  // Returns {carry into top bit, block carry-out, block sum}; every carry is
  // formed from prefix generate/propagate terms and the block carry-in.
  function automatic logic [BLOCK+1:0] block_add(
    input logic [BLOCK-1:0] x,
    input logic [BLOCK-1:0] y,
    input logic             ci
  );
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             pg;
    logic             pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    pg   = 1'b0;
    pp   = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      pg       = g[i] | (p[i] & pg);
      pp       = pp & p[i];
      c[i+1]   = pg | (pp & ci);
    end
    return {c[BLOCK-1], c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] sub_q;
  logic [STAGES-1:0] sub_d;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_d;
  logic              cm_q [STAGES];
  logic              cm_d [STAGES];
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  a_d  [STAGES];
  logic [WIDTH-1:0]  b_q  [STAGES];
  logic [WIDTH-1:0]  b_d  [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic              adv;

  assign adv      = !v_q[STAGES-1] || out_ready;
  assign in_ready = adv && rst_n;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             v_src;
      logic             sub_src;
      logic             c_src;
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] s_src;
      logic [WIDTH-1:0] s_next;
      logic [BLOCK+1:0] res;

      if (gi == 0) begin : g_head
        // Subtraction enters as a + ~b + ~cin; the inverted b travels with the beat.
        assign v_src   = in_valid && in_ready;
        assign sub_src = sub;
        assign c_src   = cin ^ sub;
        assign a_src   = a;
        assign b_src   = sub ? ~b : b;
        assign s_src   = '0;
      end else begin : g_body
        assign v_src   = v_q[gi-1];
        assign sub_src = sub_q[gi-1];
        assign c_src   = c_q[gi-1];
        assign a_src   = a_q[gi-1];
        assign b_src   = b_q[gi-1];
        assign s_src   = s_q[gi-1];
      end

      assign res = block_add(a_src[gi*BLOCK +: BLOCK], b_src[gi*BLOCK +: BLOCK], c_src);

      always_comb begin
        s_next                     = s_src;
        s_next[gi*BLOCK +: BLOCK]  = res[BLOCK-1:0];
      end

      assign v_d[gi]   = v_src;
      assign sub_d[gi] = sub_src;
      assign c_d[gi]   = res[BLOCK];
      assign cm_d[gi]  = res[BLOCK+1];
      assign a_d[gi]   = a_src;
      assign b_d[gi]   = b_src;
      assign s_d[gi]   = s_next;
    end
  endgenerate

  // Every stage advances together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      sub_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        cm_q[k] <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
      end
    end else if (adv) begin
      v_q   <= v_d;
      sub_q <= sub_d;
      c_q   <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        cm_q[k] <= cm_d[k];
        a_q[k]  <= a_d[k];
        b_q[k]  <= b_d[k];
        s_q[k]  <= s_d[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1] ^ sub_q[STAGES-1];
  assign ovf       = cm_q[STAGES-1] ^ c_q[STAGES-1];

endmodule
